debug_readback: RTL

- Debug-side reader, the counterpart of the external icache write stream.
- On command, it walks a contiguous address range of one CPU storage: icache, register file or dcache. It drives the ext_* read-address ports of cpu_top, captures the read data and streams it out as (addr, data) words over a valid/ready handshake.
- Lives in the clk_debug domain beside cpu_top and is used to dump the instruction image, registers and data memory after a program run.

---
 rtl/debug_readback.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/debug_readback.sv
// Debug-side memory walker: reads a contiguous range of icache, regfile or
// dcache through the cpu_top ext_* read ports and streams (addr, data) words.
module debug_readback #(
    parameter int DATA_WIDTH  = 32,
    parameter int IADDR_WIDTH = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int DADDR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_debug,
    input  logic                   rst_n_debug,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [1:0]             sel_i,
    input  logic [31:0]            base_addr_i,
    input  logic [CNT_WIDTH-1:0]   count_i,
    output logic [IADDR_WIDTH-1:0] ext_icache_addr_o,
    output logic [RADDR_WIDTH-1:0] ext_reg_raddr_o,
    output logic [DADDR_WIDTH-1:0] ext_dcache_raddr_o,
    input  logic [DATA_WIDTH-1:0]  ext_icache_rdata_i,
    input  logic [DATA_WIDTH-1:0]  ext_reg_rdata_i,
    input  logic [DATA_WIDTH-1:0]  ext_dcache_rdata_i,
    output logic [DATA_WIDTH-1:0]  dout_o,
    output logic [31:0]            dout_addr_o,
    output logic                   dout_valid_o,
    input  logic                   dout_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_e;

    localparam logic [1:0] SEL_IC = 2'b00;
    localparam logic [1:0] SEL_RF = 2'b01;
    localparam logic [1:0] SEL_DC = 2'b10;
    localparam logic [1:0] SEL_XX = 2'b11;

    localparam logic [31:0] IMASK = 32'hFFFF_FFFF >> (32 - IADDR_WIDTH);
    localparam logic [31:0] RMASK = 32'hFFFF_FFFF >> (32 - RADDR_WIDTH);
    localparam logic [31:0] DMASK = 32'hFFFF_FFFF >> (32 - DADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_e                 state_q;
    logic [1:0]             sel_q;
    logic [31:0]            addr_q;
    logic [31:0]            addr_d;
    logic [CNT_WIDTH-1:0]   rem_q;
    logic [IADDR_WIDTH-1:0] ic_addr_q;
    logic [RADDR_WIDTH-1:0] rf_addr_q;
    logic [DADDR_WIDTH-1:0] dc_addr_q;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic [31:0]            dout_addr_q;
    logic                   valid_q;
    logic                   done_q;
    logic                   err_q;

    // Keeps the walking address inside the target's address space.
    function automatic logic [31:0] wrap(input logic [1:0] s, input logic [31:0] a);
        case (s)
            SEL_RF:  wrap = a & RMASK;
            SEL_DC:  wrap = a & DMASK;
            default: wrap = a & IMASK;
        endcase
    endfunction

    always_comb begin
        addr_d = wrap(sel_q, addr_q + ((sel_q == SEL_RF) ? 32'd1 : 32'd4));
    end

    always_ff @(posedge clk_debug or negedge rst_n_debug) begin
        if (!rst_n_debug) begin
            state_q     <= S_IDLE;
            sel_q       <= SEL_IC;
            addr_q      <= '0;
            rem_q       <= '0;
            ic_addr_q   <= '0;
            rf_addr_q   <= '0;
            dc_addr_q   <= '0;
            dout_q      <= '0;
            dout_addr_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort_i && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            if (sel_i == SEL_XX) begin
                                err_q <= 1'b1;
                            end else if (count_i == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                sel_q   <= sel_i;
                                addr_q  <= wrap(sel_i, base_addr_i);
                                rem_q   <= count_i;
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        case (sel_q)
                            SEL_IC:  ic_addr_q <= addr_q[IADDR_WIDTH-1:0];
                            SEL_RF:  rf_addr_q <= addr_q[RADDR_WIDTH-1:0];
                            SEL_DC:  dc_addr_q <= addr_q[DADDR_WIDTH-1:0];
                            default: ;
                        endcase
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        case (sel_q)
                            SEL_RF:  dout_q <= ext_reg_rdata_i;
                            SEL_DC:  dout_q <= ext_dcache_rdata_i;
                            default: dout_q <= ext_icache_rdata_i;
                        endcase
                        dout_addr_q <= addr_q;
                        valid_q     <= 1'b1;
                        state_q     <= S_OUT;
                    end
                    S_OUT: begin
                        if (valid_q && dout_ready_i) begin
                            valid_q <= 1'b0;
                            rem_q   <= rem_q - CNT_ONE;
                            if (rem_q == CNT_ONE) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q  <= addr_d;
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ext_icache_addr_o  = ic_addr_q;
    assign ext_reg_raddr_o    = rf_addr_q;
    assign ext_dcache_raddr_o = dc_addr_q;
    assign dout_o             = dout_q;
    assign dout_addr_o        = dout_addr_q;
    assign dout_valid_o       = valid_q;
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = done_q;
    assign err_o              = err_q;

endmodule
